// File: rtl/ram_clear_dp.sv
// Dual-port synchronous word RAM with a hardware clear sequencer.
// Port A is read/write (data path), port B is read-only (instruction fetch).
// After reset, or on clear_req, the sequencer sweeps every address and writes
// clear_value. While it owns the array, both ports are ignored and busy is high.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | sweep owns the array; writes clear_value to mem[cnt_q]
//   ST_READY | ports A/B serviced; clear_req starts a new sweep next edge
module ram_clear_dp #(
  parameter int                   addr_bits   = 16,
  parameter int                   data_bits   = 8,
  parameter bit                   write_first = 1'b0,
  parameter logic [data_bits-1:0] clear_value = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic                 a_enable,
  input  logic                 a_write_enable,
  input  logic [addr_bits-1:0] a_address,
  input  logic [data_bits-1:0] a_data_in,
  output logic [data_bits-1:0] a_data_out,
  output logic                 a_valid,
  input  logic                 b_enable,
  input  logic [addr_bits-1:0] b_address,
  output logic [data_bits-1:0] b_data_out,
  output logic                 b_valid
);

  localparam int depth = 2 ** addr_bits;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [addr_bits-1:0] cnt_q, cnt_d;
  logic                 cnt_last;

  logic [data_bits-1:0] mem [depth];

  logic                 mem_we;
  logic [addr_bits-1:0] mem_waddr;
  logic [data_bits-1:0] mem_wdata;

  logic [data_bits-1:0] a_data_q, a_data_d;
  logic                 a_valid_q, a_valid_d;
  logic [data_bits-1:0] b_data_q, b_data_d;
  logic                 b_valid_q, b_valid_d;

  logic                 a_wr;
  logic                 ab_collide;

  assign cnt_last   = (cnt_q == {addr_bits{1'b1}});
  assign a_wr       = a_enable & a_write_enable;
  assign ab_collide = a_wr & (a_address == b_address);

  // State and sweep counter registers; reset restarts the sweep from address 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: finish the sweep on the last address, start one on clear_req.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_last) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        cnt_d = '0;
        if (clear_req) begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: array write port mux and next read data / valid per port.
  always_comb begin
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = a_address;
    mem_wdata = a_data_in;
    a_data_d  = a_data_q;
    a_valid_d = 1'b0;
    b_data_d  = b_data_q;
    b_valid_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = clear_value;
      end
      ST_READY: begin
        mem_we = a_wr;
        if (a_enable) begin
          a_valid_d = 1'b1;
          // Write-first forwards the incoming word; read-first returns the old one.
          if (write_first && a_write_enable) begin
            a_data_d = a_data_in;
          end else begin
            a_data_d = mem[a_address];
          end
        end
        if (b_enable) begin
          b_valid_d = 1'b1;
          if (write_first && ab_collide) begin
            b_data_d = a_data_in;
          end else begin
            b_data_d = mem[b_address];
          end
        end
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Read data and valid registers; data holds when a port is idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_data_q  <= '0;
      a_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_valid_q <= 1'b0;
    end else begin
      a_data_q  <= a_data_d;
      a_valid_q <= a_valid_d;
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
    end
  end

  // Array write; contents are deliberately not reset (the sweep initialises them).
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign a_data_out = a_data_q;
  assign a_valid    = a_valid_q;
  assign b_data_out = b_data_q;
  assign b_valid    = b_valid_q;

endmodule
